// File: rtl/cfg_pkg.sv
// cfg_pkg: shared types and constants for the fabric config loader.
// Frame layout, FSM states and beat arithmetic.
package cfg_pkg;

  localparam int CFG_FRAME_W = 18;

  localparam int V_OFF  = 0;
  localparam int V_W    = 6;
  localparam int LU_OFF = 6;
  localparam int DR_OFF = 9;
  localparam int UR_OFF = 12;
  localparam int LD_OFF = 15;
  localparam int DIR_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ASM,
    WRITE,
    HOLD,
    DONE,
    ERR
  } state_t;

  function automatic int bpf(
    input int frame_w,
    input int in_w
  );
    return (frame_w + in_w - 1) / in_w;
  endfunction

endpackage

// File: rtl/cfg_frame_asm.sv
// cfg_frame_asm: packs byte-serial beats into one config frame.
// Flags the frame on its last beat and checks the padding bits.
module cfg_frame_asm
  import cfg_pkg::*;
#(
  parameter int FRAME_W = CFG_FRAME_W,
  parameter int IN_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               beat_en,
  input  logic [IN_W-1:0]    data,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               pad_err
);

  localparam int BPF   = bpf(FRAME_W, IN_W);
  localparam int BUF_W = BPF * IN_W;
  localparam int CNT_W = (BPF > 1) ? $clog2(BPF) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [BUF_W-1:0] beat_q;
  logic [BUF_W-1:0] full;
  logic             last;

  assign last = beat_en && (cnt_q == CNT_W'(BPF - 1));

  // Full frame with the in-flight last beat spliced in
  always_comb begin
    full = beat_q;
    full[(BPF-1)*IN_W +: IN_W] = data;
  end

  assign frame_valid = last;
  assign frame       = full[FRAME_W-1:0];
  assign pad_err     = last && (|(full >> FRAME_W));

  // Beat counter and per-slot capture of earlier beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beat_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      beat_q <= '0;
    end else if (beat_en) begin
      beat_q[int'(cnt_q)*IN_W +: IN_W] <= data;
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: sequences config frames into the tile array.
// One frame per tile, written with setup and hold margins.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int FRAME_W   = CFG_FRAME_W,
  parameter int IN_W      = 8,
  parameter int WR_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [IN_W-1:0]      data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [FRAME_W-1:0]   bits_o,
  output logic [NUM_TILES-1:0] wr_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int WC_W   = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  state_t               state_q;
  logic [TILE_W-1:0]    tile_q;
  logic [WC_W-1:0]      wr_cnt_q;
  logic [NUM_TILES-1:0] tile_sel;

  logic                 beat_en;
  logic                 start_ok;
  logic                 frame_valid;
  logic [FRAME_W-1:0]   frame;
  logic                 pad_err;

  assign beat_en  = valid_i && ready_o;
  assign start_ok = start_i &&
                    ((state_q == IDLE) ||
                     (state_q == DONE) ||
                     (state_q == ERR));
  assign tile_sel = NUM_TILES'(1) << tile_q;

  cfg_frame_asm #(
    .FRAME_W (FRAME_W),
    .IN_W    (IN_W)
  ) u_asm (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .clr         (start_ok),
    .beat_en     (beat_en),
    .data        (data_i),
    .frame_valid (frame_valid),
    .frame       (frame),
    .pad_err     (pad_err)
  );

  // Load sequencer with registered handshake, bus and status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      wr_cnt_q <= '0;
      ready_o  <= 1'b0;
      bits_o   <= '0;
      wr_en_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q <= ASM;
            tile_q  <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
          end
        end
        ASM: begin
          if (frame_valid) begin
            ready_o <= 1'b0;
            if (pad_err) begin
              state_q <= ERR;
              busy_o  <= 1'b0;
              err_o   <= 1'b1;
            end else begin
              state_q  <= WRITE;
              bits_o   <= frame;
              wr_en_o  <= tile_sel;
              wr_cnt_q <= '0;
            end
          end
        end
        WRITE: begin
          if (wr_cnt_q == WC_W'(WR_CYCLES - 1)) begin
            state_q <= HOLD;
            wr_en_o <= '0;
          end else begin
            wr_cnt_q <= wr_cnt_q + WC_W'(1);
          end
        end
        HOLD: begin
          if (tile_q == TILE_W'(NUM_TILES - 1)) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            state_q <= ASM;
            tile_q  <= tile_q + TILE_W'(1);
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_o <= 1'b0;
          wr_en_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: scoreboard bench for the config loader.
// Expected tile writes are queued on stimulus and popped on wr_en.
module tb_cfg_loader;

  localparam int NT = 4;
  localparam int FW = 18;
  localparam int IW = 8;
  localparam int WC = 2;

  typedef struct {
    int          tile;
    logic [FW-1:0] frame;
  } exp_t;

  logic          clk;
  logic          rst_n_i;
  logic          start_i;
  logic [IW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [FW-1:0] bits_o;
  logic [NT-1:0] wr_en_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc_cnt = 0;
  int   t0      = 0;
  int   wr_seen = 0;
  exp_t exp_q[$];

  exp_t          mon_e;
  logic [NT-1:0] mon_prev;
  logic [NT-1:0] mon_one;
  logic [FW-1:0] mon_lat;
  int            mon_hi;

  cfg_loader #(
    .NUM_TILES (NT),
    .FRAME_W   (FW),
    .IN_W      (IW),
    .WR_CYCLES (WC)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .bits_o  (bits_o),
    .wr_en_o (wr_en_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // write monitor: pops the scoreboard on each new wr_en pulse
  always @(negedge clk) begin
    if (!rst_n_i) begin
      mon_prev = '0;
      mon_hi   = 0;
    end else begin
      vec_cnt++;
      if (!$onehot0(wr_en_o)) begin
        err_cnt++;
        $display("FAIL onehot: wr_en=%b", wr_en_o);
      end
      if (wr_en_o != '0 && mon_prev == '0) begin
        wr_seen++;
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_write: wr_en=%b bits=%h",
                   wr_en_o, bits_o);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_one = 4'b0001;
          mon_one = mon_one << mon_e.tile;
          if (wr_en_o !== mon_one || bits_o !== mon_e.frame) begin
            err_cnt++;
            $display("FAIL write: wr_en=%b bits=%h want %b %h",
                     wr_en_o, bits_o, mon_one, mon_e.frame);
          end
        end
        mon_lat = bits_o;
        mon_hi  = 1;
      end else if (wr_en_o != '0) begin
        mon_hi++;
        vec_cnt++;
        if (bits_o !== mon_lat || wr_en_o !== mon_prev) begin
          err_cnt++;
          $display("FAIL write_stable: bits=%h wr_en=%b want %h %b",
                   bits_o, wr_en_o, mon_lat, mon_prev);
        end
      end else if (mon_prev != '0) begin
        vec_cnt++;
        if (mon_hi != WC || bits_o !== mon_lat) begin
          err_cnt++;
          $display("FAIL hold: cycles=%0d bits=%h want %0d %h",
                   mon_hi, bits_o, WC, mon_lat);
        end
      end
      mon_prev = wr_en_o;
    end
  end

  function automatic logic [FW-1:0] mk(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    logic [23:0] w;
    w = {b2, b1, b0};
    return w[FW-1:0];
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic send_beat(input logic [7:0] d);
    bit got;
    got = 1'b0;
    data_i  = d;
    valid_i = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk);
    end
    #1 valid_i = 1'b0;
    if (!got) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL beat_timeout: data=%h ready=%b want 1", d, ready_o);
    end
  endtask

  task automatic send_tile(
    input int          tile,
    input logic [7:0]  b0,
    input logic [7:0]  b1,
    input logic [7:0]  b2,
    input logic [FW-1:0] exp_frame,
    input bit          push
  );
    exp_t e;
    e.tile  = tile;
    e.frame = exp_frame;
    if (push) exp_q.push_back(e);
    send_beat(b0);
    send_beat(b1);
    send_beat(b2);
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    bit got;
    int dc;
    got = 1'b0;
    dc  = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        dc  = cyc_cnt - t0;
      end
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL %s_done_timeout: done=%b want 1", name, done_o);
    end else if (dc != exp_cyc) begin
      err_cnt++;
      $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, exp_cyc);
    end
    vec_cnt++;
    if (busy_o !== 1'b0 || wr_en_o !== '0) begin
      err_cnt++;
      $display("FAIL %s_done_state: busy=%b wr_en=%b want 0 0",
               name, busy_o, wr_en_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({ready_o, busy_o, done_o, err_o} !== 4'b0000 ||
        wr_en_o !== '0 || bits_o !== '0) begin
      err_cnt++;
      $display("FAIL reset: rdy=%b busy=%b done=%b err=%b wr=%b bits=%h want 0",
               ready_o, busy_o, done_o, err_o, wr_en_o, bits_o);
    end
    #2 rst_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    pulse_start();
    for (int t = 0; t < NT; t++)
      send_tile(t, 8'h02, 8'h18, 8'h00, 18'b000001_100_000_000_010, 1'b1);
    wait_done(24, "nominal");
  endtask

  task automatic test_stall();
    logic [FW-1:0] snap;
    exp_t e;
    pulse_start();
    e.tile  = 0;
    e.frame = mk(8'h5A, 8'h3C, 8'h02);
    exp_q.push_back(e);
    send_beat(8'h5A);
    send_beat(8'h3C);
    snap = bits_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (wr_en_o !== '0 || bits_o !== snap || ready_o !== 1'b1) begin
        err_cnt++;
        $display("FAIL stall: wr=%b bits=%h rdy=%b want 0 %h 1",
                 wr_en_o, bits_o, ready_o, snap);
      end
      @(posedge clk);
    end
    #1;
    send_beat(8'h02);
    for (int t = 1; t < NT; t++)
      send_tile(t, 8'h02, 8'h18, 8'h00, mk(8'h02, 8'h18, 8'h00), 1'b1);
    wait_done(29, "stall");
  endtask

  task automatic test_pad_err();
    int w0;
    w0 = wr_seen;
    pulse_start();
    send_tile(0, 8'h11, 8'h22, 8'h01, mk(8'h11, 8'h22, 8'h01), 1'b1);
    send_tile(1, 8'h02, 8'h18, 8'h04, '0, 1'b0);
    vec_cnt++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 ||
        ready_o !== 1'b0 || wr_en_o !== '0) begin
      err_cnt++;
      $display("FAIL pad_err: err=%b busy=%b rdy=%b wr=%b want 1 0 0 0",
               err_o, busy_o, ready_o, wr_en_o);
    end
    repeat (4) @(posedge clk);
    #1;
    vec_cnt++;
    if (wr_seen - w0 != 1 || err_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL pad_writes: writes=%0d err=%b want 1 1",
               wr_seen - w0, err_o);
    end
    pulse_start();
    vec_cnt++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL pad_restart: err=%b busy=%b want 0 1", err_o, busy_o);
    end
    for (int t = 0; t < NT; t++)
      send_tile(t, 8'h02, 8'h18, 8'h00, mk(8'h02, 8'h18, 8'h00), 1'b1);
    wait_done(24, "pad_reload");
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int t = 0; t < 3; t++)
      send_tile(t, 8'h77, 8'h66, 8'h02, mk(8'h77, 8'h66, 8'h02), 1'b1);
    @(negedge clk);
    vec_cnt++;
    if (wr_en_o !== 4'b0100) begin
      err_cnt++;
      $display("FAIL rst_pre: wr=%b want 0100", wr_en_o);
    end
    #2 rst_n_i = 1'b0;
    #1;
    vec_cnt++;
    if (wr_en_o !== '0 || bits_o !== '0) begin
      err_cnt++;
      $display("FAIL rst_async: wr=%b bits=%h want 0 0", wr_en_o, bits_o);
    end
    repeat (2) @(negedge clk);
    #2 rst_n_i = 1'b1;
    data_i  = 8'h11;
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (ready_o !== 1'b0 || busy_o !== 1'b0 || wr_en_o !== '0) begin
        err_cnt++;
        $display("FAIL rst_idle: rdy=%b busy=%b wr=%b want 0 0 0",
                 ready_o, busy_o, wr_en_o);
      end
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    pulse_start();
    send_tile(0, 8'h02, 8'h18, 8'h00, mk(8'h02, 8'h18, 8'h00), 1'b1);
    e.tile  = 1;
    e.frame = mk(8'h55, 8'hAA, 8'h01);
    exp_q.push_back(e);
    send_beat(8'h55);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    vec_cnt++;
    if (busy_o !== 1'b1 || ready_o !== 1'b1 || done_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL start_ignored: busy=%b rdy=%b done=%b want 1 1 0",
               busy_o, ready_o, done_o);
    end
    send_beat(8'hAA);
    send_beat(8'h01);
    for (int t = 2; t < NT; t++)
      send_tile(t, 8'h02, 8'h18, 8'h00, mk(8'h02, 8'h18, 8'h00), 1'b1);
    wait_done(25, "start_ign");
  endtask

  task automatic test_reload();
    vec_cnt++;
    if (done_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL reload_pre: done=%b want 1", done_o);
    end
    pulse_start();
    vec_cnt++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL reload_clr: done=%b busy=%b want 0 1", done_o, busy_o);
    end
    send_tile(0, 8'hFF, 8'hFF, 8'h03, 18'h3FFFF, 1'b1);
    for (int t = 1; t < NT; t++)
      send_tile(t, 8'h0F, 8'hF0, 8'h01, mk(8'h0F, 8'hF0, 8'h01), 1'b1);
    wait_done(24, "reload");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_pad_err();
    test_async_reset();
    test_start_ignored();
    test_reload();
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_left: %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
